// File: rtl/core_pkg.sv
// Core-wide types and constants shared by the execute stage.
// Holds the ALU opcode encodings and the packed ALU request used by alu_arbiter.
// Pure declarations; no logic, latency or flow control of its own.
package core_pkg;

   localparam int CORE_DATA_WIDTH  = 32;
   localparam int CORE_SHAMT_WIDTH = 5;

   // ALU opcode encodings (the arbiter forwards these without decoding them)
   localparam logic [4:0] ADD = 5'h00;
   localparam logic [4:0] SUB = 5'h01;
   localparam logic [4:0] XOR = 5'h04;
   localparam logic [4:0] OR  = 5'h06;
   localparam logic [4:0] AND = 5'h07;
   localparam logic [4:0] SLL = 5'h08;
   localparam logic [4:0] SRL = 5'h09;
   localparam logic [4:0] SRA = 5'h0A;

   // One ALU operation request from a single requester
   typedef struct packed {
      logic [31:0] op_a;
      logic [31:0] op_b;
      logic [4:0]  alu_op;
      logic [4:0]  shamt;
   } alu_req_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: grants one of NUM_REQ requesters, searching from last_q+1.
// Latency: grant is combinational in the request cycle; pointer moves on the next edge.
// Backpressure: en_i low suppresses all grants and freezes the pointer.
module rr_arbiter #(
   parameter int NUM_REQ  = 2,
   localparam int ID_WIDTH = $clog2(NUM_REQ)
) (
   input  logic                clk_i,
   input  logic                rst_i,
   input  logic [NUM_REQ-1:0]  req_i,
   input  logic                en_i,
   output logic [NUM_REQ-1:0]  gnt_o,
   output logic [ID_WIDTH-1:0] gnt_id_o
);

   // One extra bit so last_q + NUM_REQ never overflows before the wrap subtract
   localparam logic [ID_WIDTH:0] NUM_REQ_W = (ID_WIDTH+1)'(NUM_REQ);

   logic [ID_WIDTH-1:0] last_q;
   logic [ID_WIDTH:0]   sum;
   logic [ID_WIDTH-1:0] idx;
   logic                found;

   // Scan requesters starting just after the last winner, wrapping modulo NUM_REQ
   always_comb begin
      gnt_o    = '0;
      gnt_id_o = '0;
      found    = 1'b0;
      sum      = '0;
      idx      = '0;
      for (int i = 1; i <= NUM_REQ; i++) begin
         sum = {1'b0, last_q} + (ID_WIDTH+1)'(i);
         if (sum >= NUM_REQ_W) begin
            sum = sum - NUM_REQ_W;
         end
         idx = sum[ID_WIDTH-1:0];
         if (!found && en_i && req_i[idx]) begin
            found      = 1'b1;
            gnt_o[idx] = 1'b1;
            gnt_id_o   = idx;
         end
      end
   end

   // Remember the winner; reset points at the top index so requester 0 wins first
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         last_q <= ID_WIDTH'(NUM_REQ - 1);
      end else if (found) begin
         last_q <= gnt_id_o;
      end
   end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one ALU among NUM_REQ requesters by round-robin, registering the result.
// Latency: request accepted in cycle N -> response valid in cycle N+1; 1 op/cycle sustained.
// Backpressure: a held, unconsumed response blocks all grants until rsp_ready_i rises.
module alu_arbiter
   import core_pkg::*;
#(
   parameter int DATA_WIDTH  = 32,
   parameter int SHAMT_WIDTH = 5,
   parameter int NUM_REQ     = 2,
   localparam int ID_WIDTH   = $clog2(NUM_REQ)
) (
   input  logic                   clk_i,
   input  logic                   rst_i,
   input  logic [NUM_REQ-1:0]     req_valid_i,
   output logic [NUM_REQ-1:0]     req_ready_o,
   input  alu_req_t [NUM_REQ-1:0] req_i,
   output logic [DATA_WIDTH-1:0]  alu_operands_a_o,
   output logic [DATA_WIDTH-1:0]  alu_operands_b_o,
   output logic [4:0]             alu_op_o,
   output logic [SHAMT_WIDTH-1:0] alu_shamt_o,
   input  logic [DATA_WIDTH-1:0]  alu_result_i,
   output logic                   rsp_valid_o,
   input  logic                   rsp_ready_i,
   output logic [ID_WIDTH-1:0]    rsp_id_o,
   output logic [DATA_WIDTH-1:0]  rsp_result_o
);

   // alu_req_t is fixed at the core's 32-bit datapath and 5-bit shift amount
   if (DATA_WIDTH != CORE_DATA_WIDTH || SHAMT_WIDTH != CORE_SHAMT_WIDTH) begin : g_width_check
      $error("alu_arbiter: alu_req_t requires DATA_WIDTH=32 and SHAMT_WIDTH=5");
   end
   if (NUM_REQ < 2) begin : g_num_req_check
      $error("alu_arbiter: NUM_REQ must be at least 2");
   end

   logic                slot_free;
   logic                arb_en;
   logic [NUM_REQ-1:0]  gnt;
   logic [ID_WIDTH-1:0] gnt_id;
   logic                gnt_vld;

   // The response slot can take a new result if empty or being drained this cycle
   assign slot_free   = !rsp_valid_o || rsp_ready_i;
   assign arb_en      = slot_free && !rst_i;
   assign gnt_vld     = |gnt;
   assign req_ready_o = gnt;

   rr_arbiter #(
      .NUM_REQ (NUM_REQ)
   ) u_rr_arbiter (
      .clk_i    (clk_i),
      .rst_i    (rst_i),
      .req_i    (req_valid_i),
      .en_i     (arb_en),
      .gnt_o    (gnt),
      .gnt_id_o (gnt_id)
   );

   // Steer the winner's operands to the ALU; idle drive is a harmless ADD of zeros
   always_comb begin
      alu_operands_a_o = '0;
      alu_operands_b_o = '0;
      alu_op_o         = ADD;
      alu_shamt_o      = '0;
      if (gnt_vld) begin
         alu_operands_a_o = req_i[gnt_id].op_a;
         alu_operands_b_o = req_i[gnt_id].op_b;
         alu_op_o         = req_i[gnt_id].alu_op;
         alu_shamt_o      = req_i[gnt_id].shamt;
      end
   end

   // One-entry response register: load on grant, clear on consume, hold otherwise
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         rsp_valid_o  <= 1'b0;
         rsp_id_o     <= '0;
         rsp_result_o <= '0;
      end else if (gnt_vld) begin
         rsp_valid_o  <= 1'b1;
         rsp_id_o     <= gnt_id;
         rsp_result_o <= alu_result_i;
      end else if (rsp_ready_i) begin
         rsp_valid_o  <= 1'b0;
      end
   end

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter with a small behavioural ALU hooked to its ALU port.
// Inputs change on the falling edge; all outputs are checked 1 ns later.
// Expected values are hand-computed constants in each step.
module tb_alu_arbiter;
   import core_pkg::*;

   logic            clk;
   logic            rst;
   logic [1:0]      req_valid;
   logic [1:0]      req_ready;
   alu_req_t [1:0]  req;
   logic [31:0]     alu_a;
   logic [31:0]     alu_b;
   logic [4:0]      alu_op;
   logic [4:0]      alu_shamt;
   logic [31:0]     alu_result;
   logic            rsp_valid;
   logic            rsp_ready;
   logic [0:0]      rsp_id;
   logic [31:0]     rsp_result;

   int n_checks;
   int n_fail;

   alu_arbiter #(
      .DATA_WIDTH  (32),
      .SHAMT_WIDTH (5),
      .NUM_REQ     (2)
   ) dut (
      .clk_i            (clk),
      .rst_i            (rst),
      .req_valid_i      (req_valid),
      .req_ready_o      (req_ready),
      .req_i            (req),
      .alu_operands_a_o (alu_a),
      .alu_operands_b_o (alu_b),
      .alu_op_o         (alu_op),
      .alu_shamt_o      (alu_shamt),
      .alu_result_i     (alu_result),
      .rsp_valid_o      (rsp_valid),
      .rsp_ready_i      (rsp_ready),
      .rsp_id_o         (rsp_id),
      .rsp_result_o     (rsp_result)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Behavioural ALU; unknown opcodes give a marker value
   always_comb begin
      case (alu_op)
         ADD:     alu_result = alu_a + alu_b;
         SUB:     alu_result = alu_a - alu_b;
         XOR:     alu_result = alu_a ^ alu_b;
         default: alu_result = 32'hDEAD_BEEF;
      endcase
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic set_req(input int i, input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] op, input logic [4:0] sh);
      req[i].op_a   = a;
      req[i].op_b   = b;
      req[i].alu_op = op;
      req[i].shamt  = sh;
   endtask

   task automatic check_rsp(input string tag, input logic v, input logic id, input logic [31:0] res);
      check({tag, "_valid"}, 32'(rsp_valid), 32'(v));
      check({tag, "_id"}, 32'(rsp_id), 32'(id));
      check({tag, "_result"}, rsp_result, res);
   endtask

   logic [1:0]  rr_gnt [4];
   logic [31:0] rr_res [4];

   initial begin
      n_checks  = 0;
      n_fail    = 0;
      rst       = 1'b1;
      req_valid = 2'b11;
      rsp_ready = 1'b1;
      set_req(0, 32'd0, 32'd0, ADD, 5'd0);
      set_req(1, 32'd0, 32'd0, ADD, 5'd0);
      rr_gnt = '{2'b01, 2'b10, 2'b01, 2'b10};
      rr_res = '{32'd2, 32'hFFFF_FFFE, 32'd2, 32'hFFFF_FFFE};

      // Reset held with free slot and both valid: no grant
      @(negedge clk); #1;
      check("rst_no_grant", 32'(req_ready), 32'h0);

      // Reset released, idle: reset values and idle ALU drive
      @(negedge clk);
      rst = 1'b0; req_valid = 2'b00;
      #1;
      check_rsp("reset", 1'b0, 1'b0, 32'd0);
      check("idle_op", 32'(alu_op), 32'(ADD));
      check("idle_a", alu_a, 32'd0);
      check("idle_b", alu_b, 32'd0);
      check("idle_shamt", 32'(alu_shamt), 32'd0);

      // Full load, both valid: grants 0,1,0,1 back to back, responses follow a cycle later
      set_req(0, 32'd1, 32'd1, ADD, 5'd0);
      set_req(1, 32'd3, 32'd5, SUB, 5'd0);
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         req_valid = (k < 4) ? 2'b11 : 2'b00;
         #1;
         if (k < 4) check($sformatf("rr_gnt%0d", k), 32'(req_ready), 32'(rr_gnt[k]));
         if (k > 0) check_rsp($sformatf("rr_rsp%0d", k - 1), 1'b1, rr_gnt[k-1][1], rr_res[k-1]);
      end

      // Single add from req0: pointer is at 1, so req0 wins; previous response drained
      @(negedge clk);
      req_valid = 2'b01;
      set_req(0, 32'd5, 32'd7, ADD, 5'd0);
      #1;
      check("add_gnt", 32'(req_ready), 32'h1);
      check("add_alu_a", alu_a, 32'd5);
      check("drain_valid", 32'(rsp_valid), 32'd0);

      // Backpressure: response 12 held for 3 cycles, req1 waiting but not granted
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         req_valid = 2'b10;
         rsp_ready = 1'b0;
         set_req(1, 32'h10, 32'h20, ADD, 5'd0);
         #1;
         check($sformatf("bp_gnt%0d", k), 32'(req_ready), 32'h0);
         check_rsp($sformatf("bp_hold%0d", k), 1'b1, 1'b0, 32'd12);
      end

      // Consumer ready again: req1 granted in the same cycle
      @(negedge clk);
      rsp_ready = 1'b1;
      #1;
      check("bp_release_gnt", 32'(req_ready), 32'h2);
      check_rsp("bp_release_old", 1'b1, 1'b0, 32'd12);

      @(negedge clk);
      req_valid = 2'b00;
      #1;
      check_rsp("bp_new", 1'b1, 1'b1, 32'h30);
      check("idle2_op", 32'(alu_op), 32'(ADD));
      check("idle2_a", alu_a, 32'd0);

      // XOR pass-through from req1 with a non-zero shift amount
      @(negedge clk);
      req_valid = 2'b10;
      set_req(1, 32'hF0F0_F0F0, 32'h0FF0_0FF0, XOR, 5'd3);
      #1;
      check("xor_gnt", 32'(req_ready), 32'h2);
      check("xor_op", 32'(alu_op), 32'(XOR));
      check("xor_shamt", 32'(alu_shamt), 32'd3);

      // Undecoded opcode from req0 passes through unchanged
      @(negedge clk);
      req_valid = 2'b01;
      set_req(0, 32'd9, 32'd9, 5'h1F, 5'd0);
      #1;
      check("raw_op_gnt", 32'(req_ready), 32'h1);
      check("raw_op", 32'(alu_op), 32'h1F);
      check_rsp("xor_rsp", 1'b1, 1'b1, 32'hFF00_FF00);

      @(negedge clk);
      req_valid = 2'b00;
      rsp_ready = 1'b0;
      #1;
      check_rsp("raw_rsp", 1'b1, 1'b0, 32'hDEAD_BEEF);

      // Reset while a response is held: discarded, no grant during reset
      @(negedge clk);
      rst = 1'b1;
      req_valid = 2'b11;
      #1;
      check("midrst_no_grant", 32'(req_ready), 32'h0);

      // After reset: slot empty and req0 wins first even though req0 won last
      @(negedge clk);
      rst = 1'b0;
      rsp_ready = 1'b1;
      set_req(0, 32'd1, 32'd1, ADD, 5'd0);
      set_req(1, 32'd3, 32'd5, SUB, 5'd0);
      #1;
      check_rsp("midrst", 1'b0, 1'b0, 32'd0);
      check("midrst_first_gnt", 32'(req_ready), 32'h1);

      @(negedge clk);
      #1;
      check("midrst_second_gnt", 32'(req_ready), 32'h2);
      check_rsp("midrst_rsp0", 1'b1, 1'b0, 32'd2);

      @(negedge clk);
      req_valid = 2'b00;
      #1;
      check_rsp("midrst_rsp1", 1'b1, 1'b1, 32'hFFFF_FFFE);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
